// File: rtl/csd_requant.sv
// Two-stage requantizer S(NB_INPUT,NBF_INPUT) -> S(NB_OUTPUT,NBF_OUTPUT): round in S1, saturate in S2.
// Define CSD_REQUANT_CONVERGENT_EN to switch S1 from round-half-up to round-half-to-even.
module csd_requant #(
    parameter int NB_INPUT   = 34,
    parameter int NBF_INPUT  = 27,
    parameter int NB_OUTPUT  = 23,
    parameter int NBF_OUTPUT = 18,
    parameter int NB_SATCNT  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NB_INPUT-1:0]  in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NB_OUTPUT-1:0] out,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 sat_clr,
    output logic [NB_SATCNT-1:0] sat_cnt
);

    localparam int DROP_F = NBF_INPUT - NBF_OUTPUT;
    localparam int DROP_I = (NB_INPUT - NBF_INPUT) - (NB_OUTPUT - NBF_OUTPUT);
    // Width of the rounded value before saturation (equals NB_INPUT+1-DROP_F).
    localparam int NB_K   = NB_OUTPUT + DROP_I + 1;

    if (DROP_F < 1 || DROP_I < 1) begin : g_param_check
        $error("csd_requant: DROP_F and DROP_I must both be >= 1");
    end

    // Rounds one product word; the extra MSB keeps the rounding add from wrapping.
    function automatic logic [NB_K-1:0] round_fn(input logic [NB_INPUT-1:0] x);
        logic [NB_INPUT:0] half;
        logic [NB_INPUT:0] r;
        half = (NB_INPUT+1)'(1) << (DROP_F - 1);
`ifdef CSD_REQUANT_CONVERGENT_EN
        if ((x[DROP_F-1:0] == half[DROP_F-1:0]) && (x[DROP_F] == 1'b0)) begin
            r = {x[NB_INPUT-1], x};
        end else begin
            r = {x[NB_INPUT-1], x} + half;
        end
`else
        r = {x[NB_INPUT-1], x} + half;
`endif
        return r[NB_INPUT:DROP_F];
    endfunction

    // Returns {sat_flag, clipped value}.
    function automatic logic [NB_OUTPUT:0] sat_fn(input logic [NB_K-1:0] k);
        logic [DROP_I+1:0] top;
        top = k[NB_K-1:NB_OUTPUT-1];
        if ((top == {(DROP_I+2){1'b0}}) || (top == {(DROP_I+2){1'b1}})) begin
            return {1'b0, k[NB_OUTPUT-1:0]};
        end else if (k[NB_K-1] == 1'b1) begin
            return {1'b1, 1'b1, {(NB_OUTPUT-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(NB_OUTPUT-1){1'b1}}};
        end
    endfunction

    logic                 v1_q, v1_d;
    logic [NB_K-1:0]      k1_q, k1_d;
    logic                 v2_q, v2_d;
    logic [NB_OUTPUT-1:0] out_q, out_d;
    logic                 sat_q, sat_d;
    logic [NB_SATCNT-1:0] cnt_q, cnt_d;
    logic                 s2_load_s;
    logic                 s1_load_s;
    logic [NB_OUTPUT:0]   sat_res_s;

    // Pipeline advance and saturation-counter next-state logic.
    always_comb begin
        s2_load_s = !v2_q || out_ready;
        s1_load_s = !v1_q || s2_load_s;
        sat_res_s = sat_fn(k1_q);
        v1_d      = v1_q;
        k1_d      = k1_q;
        v2_d      = v2_q;
        out_d     = out_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        if (s1_load_s) begin
            v1_d = in_valid;
            if (in_valid) begin
                k1_d = round_fn(in);
            end else begin
                k1_d = k1_q;
            end
        end else begin
            v1_d = v1_q;
        end
        if (s2_load_s) begin
            v2_d = v1_q;
            if (v1_q) begin
                out_d = sat_res_s[NB_OUTPUT-1:0];
                sat_d = sat_res_s[NB_OUTPUT];
            end else begin
                out_d = out_q;
            end
        end else begin
            v2_d = v2_q;
        end
        // Clear has priority over a coincident increment; the count sticks at all-ones.
        if (sat_clr) begin
            cnt_d = {NB_SATCNT{1'b0}};
        end else if (v2_q && out_ready && sat_q && (cnt_q != {NB_SATCNT{1'b1}})) begin
            cnt_d = cnt_q + NB_SATCNT'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            k1_q  <= {NB_K{1'b0}};
            v2_q  <= 1'b0;
            out_q <= {NB_OUTPUT{1'b0}};
            sat_q <= 1'b0;
            cnt_q <= {NB_SATCNT{1'b0}};
        end else begin
            v1_q  <= v1_d;
            k1_q  <= k1_d;
            v2_q  <= v2_d;
            out_q <= out_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = !v1_q || !v2_q || out_ready;
    assign out       = out_q;
    assign out_sat   = sat_q;
    assign out_valid = v2_q;
    assign sat_cnt   = cnt_q;

endmodule
